label_table_mp: RTL and testbench

Parametrised, dual-read-port label descriptor table for the OSECPU core. Holds one descriptor per label ID: type code, base address, element count and valid flag. Serves two independent registered lookups per cycle, e.g. one for the pointer-load path and one for the branch/code-label path. Adds a hardware invalidation sweep after reset or on request, and an optional access-bounds check.

---
 rtl/label_table_mp.sv | 150 +++++++++++++++
 tb/tb_label_table_mp.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/label_table_mp.sv
// Label descriptor table: one {valid, typ, base, count} word per label ID, two registered read ports, hardware invalidation sweep.
// Latency: 1 cycle per read port with write-first bypass; busy=1 for ENTRIES cycles after reset or clr, and writes are dropped meanwhile.
// Optional LABEL_TABLE_BOUNDS_EN adds the ofs >= count check to oob_a/oob_b; otherwise oob_x = !vld_x.
module label_table_mp #(
    parameter int LBID_W  = 12,
    parameter int ENTRIES = 256,
    parameter int TYP_W   = 8,
    parameter int BASE_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              we,
    input  logic [LBID_W-1:0] lbidw,
    input  logic [TYP_W-1:0]  typw,
    input  logic [BASE_W-1:0] basew,
    input  logic [CNT_W-1:0]  countw,
    input  logic              re_a,
    input  logic [LBID_W-1:0] lbid_a,
    input  logic [CNT_W-1:0]  ofs_a,
    output logic              vld_a,
    output logic [TYP_W-1:0]  typ_a,
    output logic [BASE_W-1:0] base_a,
    output logic [CNT_W-1:0]  count_a,
    output logic              oob_a,
    input  logic              re_b,
    input  logic [LBID_W-1:0] lbid_b,
    input  logic [CNT_W-1:0]  ofs_b,
    output logic              vld_b,
    output logic [TYP_W-1:0]  typ_b,
    output logic [BASE_W-1:0] base_b,
    output logic [CNT_W-1:0]  count_b,
    output logic              oob_b
);
    localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [LBID_W:0] ENT_N = (LBID_W+1)'(ENTRIES);
    localparam logic [AW-1:0]   LAST  = AW'(ENTRIES - 1);

    typedef struct packed {
        logic              vld;
        logic [TYP_W-1:0]  typ;
        logic [BASE_W-1:0] base;
        logic [CNT_W-1:0]  count;
    } ent_t;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    ent_t          mem [ENTRIES];
    ent_t          wr_ent, rd_a, rd_b, q_a, q_b;
    logic          wr_acc, oob_a_d, oob_b_d;

    assign busy   = (state_q == SWEEP);
    assign wr_acc = we && !busy && ({1'b0, lbidw} < ENT_N);
    assign wr_ent = '{vld: (typw != '0), typ: typw, base: basew, count: countw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (clr) begin
            state_d = SWEEP;
            ptr_d   = '0;
        end else if (state_q == SWEEP) begin
            if (ptr_q == LAST) begin
                state_d = IDLE;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // The sweep owns the write port; user writes only land once idle.
    always_ff @(posedge clk) begin
        if (busy)
            mem[ptr_q] <= '0;
        else if (wr_acc)
            mem[lbidw[AW-1:0]] <= wr_ent;
    end

    always_comb begin
        rd_a = '0;
        if (!busy && ({1'b0, lbid_a} < ENT_N)) begin
            if (wr_acc && (lbid_a == lbidw))
                rd_a = wr_ent;
            else
                rd_a = mem[lbid_a[AW-1:0]];
        end
    end

    always_comb begin
        rd_b = '0;
        if (!busy && ({1'b0, lbid_b} < ENT_N)) begin
            if (wr_acc && (lbid_b == lbidw))
                rd_b = wr_ent;
            else
                rd_b = mem[lbid_b[AW-1:0]];
        end
    end

`ifdef LABEL_TABLE_BOUNDS_EN
    assign oob_a_d = !rd_a.vld || (ofs_a >= rd_a.count);
    assign oob_b_d = !rd_b.vld || (ofs_b >= rd_b.count);
`else
    logic unused_ofs;
    assign unused_ofs = ^{ofs_a, ofs_b};
    assign oob_a_d    = !rd_a.vld;
    assign oob_b_d    = !rd_b.vld;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a   <= '0;
            oob_a <= 1'b1;
            q_b   <= '0;
            oob_b <= 1'b1;
        end else begin
            if (re_a) begin
                q_a   <= rd_a;
                oob_a <= oob_a_d;
            end
            if (re_b) begin
                q_b   <= rd_b;
                oob_b <= oob_b_d;
            end
        end
    end

    assign vld_a   = q_a.vld;
    assign typ_a   = q_a.typ;
    assign base_a  = q_a.base;
    assign count_a = q_a.count;
    assign vld_b   = q_b.vld;
    assign typ_b   = q_b.typ;
    assign base_b  = q_b.base;
    assign count_b = q_b.count;
endmodule

// File: tb/tb_label_table_mp.sv
// Bench for label_table_mp: directed scenarios plus random traffic, with expectations queued per cycle and checked by a separate monitor.
module tb_label_table_mp;
    localparam int ENTRIES = 256;

    logic        clk, rst_n, clr, busy, we;
    logic [11:0] lbidw, lbid_a, lbid_b;
    logic [7:0]  typw, typ_a, typ_b;
    logic [15:0] basew, countw, base_a, base_b, count_a, count_b, ofs_a, ofs_b;
    logic        re_a, re_b, vld_a, vld_b, oob_a, oob_b;

    label_table_mp dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
        .we(we), .lbidw(lbidw), .typw(typw), .basew(basew), .countw(countw),
        .re_a(re_a), .lbid_a(lbid_a), .ofs_a(ofs_a), .vld_a(vld_a), .typ_a(typ_a),
        .base_a(base_a), .count_a(count_a), .oob_a(oob_a),
        .re_b(re_b), .lbid_b(lbid_b), .ofs_b(ofs_b), .vld_b(vld_b), .typ_b(typ_b),
        .base_b(base_b), .count_b(count_b), .oob_b(oob_b)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        vld;
        logic [7:0]  typ;
        logic [15:0] base;
        logic [15:0] count;
    } ment_t;

    typedef struct packed {
        logic        vld;
        logic [7:0]  typ;
        logic [15:0] base;
        logic [15:0] count;
        logic        oob;
    } res_t;

    typedef struct packed {
        logic busy;
        res_t a;
        res_t b;
    } exp_t;

    ment_t  m_mem [ENTRIES];
    int     m_left;
    res_t   m_out_a, m_out_b;
    exp_t   q[$];
    exp_t   mon_e;
    int     tests = 0;
    int     errs  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic res_t mread(input logic [11:0] id, input logic [15:0] ofs, input bit bz);
        res_t r;
        r = '0;
        if (!bz && id < ENTRIES) begin
            r.vld   = m_mem[id[7:0]].vld;
            r.typ   = m_mem[id[7:0]].typ;
            r.base  = m_mem[id[7:0]].base;
            r.count = m_mem[id[7:0]].count;
        end
`ifdef LABEL_TABLE_BOUNDS_EN
        r.oob = !r.vld || (ofs >= r.count);
`else
        r.oob = !r.vld;
`endif
        return r;
    endfunction

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic step();
        bit   bz;
        exp_t e;
        bz = (m_left > 0);
        if (we && !bz && lbidw < ENTRIES)
            m_mem[lbidw[7:0]] = '{vld: (typw != 0), typ: typw, base: basew, count: countw};
        if (re_a) m_out_a = mread(lbid_a, ofs_a, bz);
        if (re_b) m_out_b = mread(lbid_b, ofs_b, bz);
        if (clr) begin
            m_left = ENTRIES;
            for (int i = 0; i < ENTRIES; i++) m_mem[i] = '0;
        end else if (m_left > 0) begin
            m_left--;
        end
        e.busy = (m_left > 0);
        e.a = m_out_a;
        e.b = m_out_b;
        q.push_back(e);
        @(negedge clk);
        we = 0; re_a = 0; re_b = 0; clr = 0;
    endtask

    task automatic wr(input logic [11:0] id, input logic [7:0] t, input logic [15:0] b, input logic [15:0] c);
        we = 1; lbidw = id; typw = t; basew = b; countw = c;
    endtask

    task automatic rda(input logic [11:0] id, input logic [15:0] o);
        re_a = 1; lbid_a = id; ofs_a = o;
    endtask

    task automatic rdb(input logic [11:0] id, input logic [15:0] o);
        re_b = 1; lbid_b = id; ofs_b = o;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("busy",    busy,    mon_e.busy);
            chk("vld_a",   vld_a,   mon_e.a.vld);
            chk("typ_a",   typ_a,   mon_e.a.typ);
            chk("base_a",  base_a,  mon_e.a.base);
            chk("count_a", count_a, mon_e.a.count);
            chk("oob_a",   oob_a,   mon_e.a.oob);
            chk("vld_b",   vld_b,   mon_e.b.vld);
            chk("typ_b",   typ_b,   mon_e.b.typ);
            chk("base_b",  base_b,  mon_e.b.base);
            chk("count_b", count_b, mon_e.b.count);
            chk("oob_b",   oob_b,   mon_e.b.oob);
        end
    end

    logic [7:0] typs [6];

    initial begin
        typs[0] = 8'h00; typs[1] = 8'h01; typs[2] = 8'h02;
        typs[3] = 8'h05; typs[4] = 8'h0D; typs[5] = 8'h86;
        rst_n = 0; clr = 0; we = 0; re_a = 0; re_b = 0;
        lbidw = 0; typw = 0; basew = 0; countw = 0;
        lbid_a = 0; lbid_b = 0; ofs_a = 0; ofs_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  busy,    1);
        chk("rst_vld_a", vld_a,   0);
        chk("rst_typ_a", typ_a,   0);
        chk("rst_oob_a", oob_a,   1);
        chk("rst_vld_b", vld_b,   0);
        chk("rst_cnt_b", count_b, 0);
        chk("rst_oob_b", oob_b,   1);
        for (int i = 0; i < ENTRIES; i++) m_mem[i] = '0;
        m_left  = ENTRIES;
        m_out_a = '{vld: 0, typ: 0, base: 0, count: 0, oob: 1};
        m_out_b = m_out_a;
        rst_n = 1;

        // Reset sweep, with a dropped write and a read while busy.
        for (int i = 0; i < ENTRIES; i++) begin
            if (i == 10) wr(12'd5, 8'h02, 16'h1234, 16'h0004);
            if (i == 20) rda(12'd5, 16'h0000);
            step();
        end
        rda(12'd5, 16'h0000); step();

        wr(12'h010, 8'h02, 16'h1000, 16'h0040); step();
        rda(12'h010, 16'h0000); rdb(12'h010, 16'h0000); step();
        rda(12'h010, 16'h003F); rdb(12'h010, 16'h0040); step();
        step();

        wr(12'd7, 8'h86, 16'h0200, 16'h0010); rda(12'd7, 16'h0001); rdb(12'd7, 16'h0010); step();
        wr(12'd7, 8'h00, 16'h0300, 16'h0020); step();
        rda(12'd7, 16'h0000); step();

        wr(12'd300, 8'h02, 16'hBEEF, 16'h0008); step();
        rda(12'd300, 16'h0000); rdb(12'd255, 16'h0000); step();

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 1)
                wr(($urandom_range(0, 9) == 0) ? 12'($urandom_range(256, 4095)) : 12'($urandom_range(0, 15)),
                   typs[$urandom_range(0, 5)], 16'($urandom), 16'($urandom_range(0, 8)));
            if ($urandom_range(0, 9) < 7)
                rda(($urandom_range(0, 9) == 0) ? 12'($urandom_range(256, 4095)) : 12'($urandom_range(0, 15)),
                    16'($urandom_range(0, 9)));
            if ($urandom_range(0, 9) < 7)
                rdb(12'($urandom_range(0, 15)), 16'($urandom_range(0, 9)));
            step();
        end

        // Restart the sweep part-way through and confirm everything is invalid afterwards.
        clr = 1; step();
        for (int i = 0; i < 100; i++) step();
        clr = 1; rda(12'd3, 16'h0000); step();
        for (int i = 0; i < ENTRIES; i++) step();
        for (int i = 0; i <= 16; i++) begin
            rda(12'(i), 16'h0000); rdb(12'(16 - i), 16'h0000); step();
        end
        step();

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
